// File: rtl/ins_loader.sv
// UART boot loader: receives a framed little-endian program image and writes it
// into instruction RAM, holding the CPU in reset until the checksum verifies.
module ins_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]       HDR_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {F_HDR, F_LEN, F_DATA, F_CHK} f_state_t;

    rx_state_t        rx_state;
    logic             rx_s1, rx_s2, rx_q;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic             frame_err;

    // Bit receiver: rx_q delays the synchronised line for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_q       <= 1'b1;
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rxd;
            rx_s2      <= rx_s1;
            rx_q       <= rx_s2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_q && !rx_s2) begin
                        cnt      <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s2, shreg[7:1]};
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                        else                 bit_idx  <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt      <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s2) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    f_state_t         f_state;
    logic [IDX_W-1:0] n_words;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       byte_idx;
    logic [7:0]       acc;
    logic [23:0]      word_buf;

    // Frame parser; DONE and ERR are expressed by the flags and fall back into HDR
    always_ff @(posedge clk) begin
        if (!rst) begin
            f_state   <= F_HDR;
            n_words   <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            acc       <= '0;
            word_buf  <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cpu_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            if (frame_err && f_state != F_HDR) begin
                err     <= 1'b1;
                busy    <= 1'b0;
                f_state <= F_HDR;
            end else if (byte_valid) begin
                case (f_state)
                    F_HDR: begin
                        if (rx_byte == HDR_BYTE) begin
                            busy    <= 1'b1;
                            cpu_rst <= 1'b1;
                            done    <= 1'b0;
                            err     <= 1'b0;
                            f_state <= F_LEN;
                        end
                    end
                    F_LEN: begin
                        if (rx_byte == 8'd0 || 32'(rx_byte) > DEPTH) begin
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            f_state <= F_HDR;
                        end else begin
                            n_words  <= IDX_W'(rx_byte);
                            word_idx <= '0;
                            byte_idx <= '0;
                            acc      <= '0;
                            f_state  <= F_DATA;
                        end
                    end
                    F_DATA: begin
                        acc      <= acc ^ rx_byte;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            ram_we    <= 1'b1;
                            ram_addr  <= word_idx[ADDR_W-1:0];
                            ram_wdata <= {rx_byte, word_buf};
                            word_idx  <= word_idx + IDX_W'(1);
                            if (word_idx + IDX_W'(1) == n_words) f_state <= F_CHK;
                        end else begin
                            word_buf <= {rx_byte, word_buf[23:8]};
                        end
                    end
                    F_CHK: begin
                        busy    <= 1'b0;
                        f_state <= F_HDR;
                        if (rx_byte == acc) begin
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: f_state <= F_HDR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ins_loader.sv
// Directed bench for ins_loader with 4 clocks per UART bit and a 64-word RAM.
module tb_ins_loader;

    localparam int unsigned CPB    = 4;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned GAP    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rxd;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              cpu_rst, busy, done, err;

    int checks = 0;
    int passed = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    logic [7:0]        tx_q[$];

    ins_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rxd(rxd),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Log every RAM write away from the active edge
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            wr_addr_q.push_back(ram_addr);
            wr_data_q.push_back(ram_wdata);
        end
    end

    function automatic logic [31:0] wd(int i);
        return (i < wr_data_q.size()) ? wr_data_q[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [ADDR_W-1:0] wa(int i);
        return (i < wr_addr_q.size()) ? wr_addr_q[i] : {ADDR_W{1'bx}};
    endfunction

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stop_bit;
        tick(CPB);
        rxd = 1'b1;
        tick(GAP);
    endtask

    task automatic send_range(int first, int last);
        for (int i = first; i <= last; i++) send_byte(tx_q[i], 1'b1);
    endtask

    task automatic make_good_frame();
        logic [7:0] x;
        tx_q = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        x = 8'h00;
        for (int i = 2; i < 10; i++) x = x ^ tx_q[i];
        tx_q.push_back(x);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rxd = 1'b1;
        tick(3);
        checks++; if (ram_we !== 1'b0) $display("FAIL reset_ram_we: got %b want 0", ram_we); else passed++;
        checks++; if (ram_addr !== '0) $display("FAIL reset_ram_addr: got %h want 0", ram_addr); else passed++;
        checks++; if (ram_wdata !== 32'h0) $display("FAIL reset_ram_wdata: got %h want 0", ram_wdata); else passed++;
        checks++; if (cpu_rst !== 1'b1) $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_good_frame();
        clear_log();
        make_good_frame();
        send_range(0, 0);
        checks++; if (busy !== 1'b1) $display("FAIL good_hdr_busy: got %b want 1", busy); else passed++;
        checks++; if (cpu_rst !== 1'b1) $display("FAIL good_hdr_cpu_rst: got %b want 1", cpu_rst); else passed++;
        send_range(1, 10);
        checks++; if (wr_addr_q.size() != 2) $display("FAIL good_write_count: got %0d want 2", wr_addr_q.size()); else passed++;
        checks++; if (wa(0) !== 6'd0) $display("FAIL good_addr0: got %h want 0", wa(0)); else passed++;
        checks++; if (wd(0) !== 32'h0050_0013) $display("FAIL good_data0: got %h want 00500013", wd(0)); else passed++;
        checks++; if (wa(1) !== 6'd1) $display("FAIL good_addr1: got %h want 1", wa(1)); else passed++;
        checks++; if (wd(1) !== 32'h0010_0093) $display("FAIL good_data1: got %h want 00100093", wd(1)); else passed++;
        checks++; if (done !== 1'b1) $display("FAIL good_done: got %b want 1", done); else passed++;
        checks++; if (cpu_rst !== 1'b0) $display("FAIL good_cpu_rst: got %b want 0", cpu_rst); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL good_busy: got %b want 0", busy); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL good_err: got %b want 0", err); else passed++;
    endtask

    task automatic test_bad_checksum();
        clear_log();
        make_good_frame();
        tx_q[10] = ~tx_q[10];
        send_range(0, 10);
        checks++; if (wr_addr_q.size() != 2) $display("FAIL badchk_write_count: got %0d want 2", wr_addr_q.size()); else passed++;
        checks++; if (err !== 1'b1) $display("FAIL badchk_err: got %b want 1", err); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL badchk_done: got %b want 0", done); else passed++;
        checks++; if (cpu_rst !== 1'b1) $display("FAIL badchk_cpu_rst: got %b want 1", cpu_rst); else passed++;
        make_good_frame();
        send_range(0, 10);
        checks++; if (err !== 1'b0) $display("FAIL recover_err: got %b want 0", err); else passed++;
        checks++; if (done !== 1'b1) $display("FAIL recover_done: got %b want 1", done); else passed++;
        checks++; if (cpu_rst !== 1'b0) $display("FAIL recover_cpu_rst: got %b want 0", cpu_rst); else passed++;
    endtask

    task automatic test_noise_glitch_len();
        logic [7:0] x;
        clear_log();
        tx_q = '{8'h00, 8'hFF, 8'h5A};
        send_range(0, 2);
        checks++; if (busy !== 1'b0) $display("FAIL noise_busy: got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b1) $display("FAIL noise_done: got %b want 1", done); else passed++;
        checks++; if (wr_addr_q.size() != 0) $display("FAIL noise_writes: got %0d want 0", wr_addr_q.size()); else passed++;

        // A spurious byte inside the data phase would corrupt the word
        tx_q = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        x = 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF;
        tx_q.push_back(x);
        send_range(0, 1);
        rxd = 1'b0;
        tick(1);
        rxd = 1'b1;
        tick(4 * CPB);
        send_range(2, 6);
        checks++; if (wr_addr_q.size() != 1) $display("FAIL glitch_write_count: got %0d want 1", wr_addr_q.size()); else passed++;
        checks++; if (wd(0) !== 32'hEFBE_ADDE) $display("FAIL glitch_data: got %h want efbeadde", wd(0)); else passed++;
        checks++; if (done !== 1'b1) $display("FAIL glitch_done: got %b want 1", done); else passed++;

        clear_log();
        tx_q = '{8'hA5, 8'h00, 8'hA5, 8'h41};
        send_range(0, 1);
        checks++; if (err !== 1'b1) $display("FAIL len0_err: got %b want 1", err); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL len0_busy: got %b want 0", busy); else passed++;
        checks++; if (cpu_rst !== 1'b1) $display("FAIL len0_cpu_rst: got %b want 1", cpu_rst); else passed++;
        send_range(2, 2);
        checks++; if (err !== 1'b0) $display("FAIL len_hdr_clears_err: got %b want 0", err); else passed++;
        send_range(3, 3);
        checks++; if (err !== 1'b1) $display("FAIL len41_err: got %b want 1", err); else passed++;
        checks++; if (wr_addr_q.size() != 0) $display("FAIL len_writes: got %0d want 0", wr_addr_q.size()); else passed++;
    endtask

    task automatic test_framing();
        clear_log();
        tx_q = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93};
        send_range(0, 6);
        send_byte(8'h00, 1'b0);
        checks++; if (err !== 1'b1) $display("FAIL frm_err: got %b want 1", err); else passed++;
        checks++; if (wr_addr_q.size() != 1) $display("FAIL frm_write_count: got %0d want 1", wr_addr_q.size()); else passed++;
        checks++; if (wa(0) !== 6'd0) $display("FAIL frm_addr0: got %h want 0", wa(0)); else passed++;
        checks++; if (cpu_rst !== 1'b1) $display("FAIL frm_cpu_rst: got %b want 1", cpu_rst); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL frm_busy: got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL frm_done: got %b want 0", done); else passed++;
    endtask

    task automatic test_full_size();
        logic [7:0] x;
        int bad;
        clear_log();
        tx_q = '{8'hA5, 8'h40};
        x = 8'h00;
        for (int i = 0; i < 256; i++) begin
            tx_q.push_back(8'(i));
            x = x ^ 8'(i);
        end
        tx_q.push_back(x);
        send_range(0, 258);
        bad = 0;
        for (int w = 0; w < 64; w++) begin
            if (wa(w) !== 6'(w) ||
                wd(w) !== {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}) bad++;
        end
        checks++; if (wr_addr_q.size() != 64) $display("FAIL full_write_count: got %0d want 64", wr_addr_q.size()); else passed++;
        checks++; if (bad != 0) $display("FAIL full_word_mismatches: got %0d want 0", bad); else passed++;
        checks++; if (wa(63) !== 6'd63) $display("FAIL full_last_addr: got %h want 3f", wa(63)); else passed++;
        checks++; if (wd(63) !== 32'hFFFE_FDFC) $display("FAIL full_last_data: got %h want fffefdfc", wd(63)); else passed++;
        checks++; if (done !== 1'b1) $display("FAIL full_done: got %b want 1", done); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        clear_log();
        tx_q = '{8'hA5, 8'h40};
        for (int i = 0; i < 42; i++) tx_q.push_back(8'(i + 8'h30));
        send_range(0, 43);
        checks++; if (wr_addr_q.size() != 10) $display("FAIL mid_pre_writes: got %0d want 10", wr_addr_q.size()); else passed++;
        // Start byte 3 of word 10, then reset while it is on the wire
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b1;
            tick(CPB);
        end
        rst = 1'b0;
        tick(1);
        checks++; if (ram_we !== 1'b0) $display("FAIL mid_ram_we: got %b want 0", ram_we); else passed++;
        checks++; if (ram_addr !== '0) $display("FAIL mid_ram_addr: got %h want 0", ram_addr); else passed++;
        checks++; if (ram_wdata !== 32'h0) $display("FAIL mid_ram_wdata: got %h want 0", ram_wdata); else passed++;
        checks++; if (cpu_rst !== 1'b1) $display("FAIL mid_cpu_rst: got %b want 1", cpu_rst); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL mid_done: got %b want 0", done); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL mid_err: got %b want 0", err); else passed++;
        rxd = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(25 * CPB);
        checks++; if (wr_addr_q.size() != 10) $display("FAIL mid_post_writes: got %0d want 10", wr_addr_q.size()); else passed++;
    endtask

    initial begin
        rst = 1'b0;
        rxd = 1'b1;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_noise_glitch_len();
        test_framing();
        test_full_size();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
